// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Control FSM for a multicycle MIPS datapath. Decodes opcode/funct from the
// instruction register into per-cycle datapath strobes and the 3-bit ALU op
// code, uses the ALU zero flag for beq, stalls on the memory handshake and
// counts retired instructions.
//
// Ports
//   clk         in   1      system clock, all state on rising edge
//   reset       in   1      asynchronous, active-low reset
//   opcode      in   6      instr[31:26] from instruction register
//   funct       in   6      instr[5:0] from instruction register
//   zero        in   1      ALU zero flag
//   mem_ready   in   1      memory access completes this cycle
//   pcen        out  1      PC write enable = pcwrite | (branch & zero)
//   iord        out  1      0: mem addr = PC, 1: mem addr = ALUOut
//   memwrite    out  1      memory write strobe
//   irwrite     out  1      instruction register load
//   regdst      out  1      1: dest = rd, 0: dest = rt
//   memtoreg    out  1      1: writeback from data reg, 0: from ALUOut
//   regwrite    out  1      register file write strobe
//   alusrca     out  1      0: PC, 1: reg A
//   alusrcb     out  2      00 reg B, 01 const 4, 10 signimm, 11 signimm<<2
//   pcsrc       out  2      00 ALU result, 01 ALUOut, 10 jump target
//   alucontrol  out  3      000 slt, 001 sub, 101 add, 110 or, 111 and
//   illegal     out  1      one-cycle pulse after an unknown opcode/funct
//   instret     out  CNT_W  retired-instruction count, wraps
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcen,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEXEC,
        S_ADDIWB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_SLT = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic pcwrite;
    logic branch;
    logic retire;
    logic irwrite_c;
    logic memwrite_c;
    logic regwrite_c;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        illegal_d  = 1'b0;
        retire     = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_SLT;

        unique case (state_q)
            S_FETCH: begin
                // ALU computes PC+4 every fetch cycle; only committed on ready.
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                if (mem_ready) begin
                    irwrite_c = 1'b1;
                    pcwrite   = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch target computed while the opcode decodes.
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                unique case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        // PC already advanced in FETCH, so the bad word is a NOP.
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                iord = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                iord       = 1'b1;
                memwrite_c = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                state_d = S_ALUWB;
                unique case (funct)
                    6'b100000: alucontrol = ALU_ADD;
                    6'b100010: alucontrol = ALU_SUB;
                    6'b100100: alucontrol = ALU_AND;
                    6'b100101: alucontrol = ALU_OR;
                    6'b101010: alucontrol = ALU_SLT;
                    default: begin
                        alucontrol = ALU_ADD;
                        illegal_d  = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                branch     = 1'b1;
                pcsrc      = 2'b01;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    // While reset is held the FSM sits in FETCH, which would otherwise raise
    // irwrite/pcen on mem_ready; gate the side-effecting strobes directly.
    assign pcen     = reset & (pcwrite | (branch & zero));
    assign irwrite  = reset & irwrite_c;
    assign memwrite = reset & memwrite_c;
    assign regwrite = reset & regwrite_c;
    assign illegal  = illegal_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Directed bench for mips_multicycle_ctrl with a 4-bit retired counter.
// Outputs are packed into a 16-bit control word, msb first:
//   pcen iord memwrite irwrite | regdst memtoreg regwrite alusrca |
//   alusrcb[1:0] pcsrc[1:0]    | alucontrol[2:0] illegal
// Expected words below are hand-derived from the per-state behaviour.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;

    // Hand-computed control words.
    localparam logic [15:0] W_FETCH_RDY  = 16'h904A; // pcen irwrite, b=01, add
    localparam logic [15:0] W_FETCH_WAIT = 16'h004A; // b=01, add, no strobes
    localparam logic [15:0] W_DECODE     = 16'h00CA; // b=11, add
    localparam logic [15:0] W_MEMADR     = 16'h018A; // a=1, b=10, add
    localparam logic [15:0] W_MEMREAD    = 16'h4000; // iord
    localparam logic [15:0] W_MEMWB      = 16'h0600; // memtoreg regwrite
    localparam logic [15:0] W_MEMWRITE   = 16'h6000; // iord memwrite
    localparam logic [15:0] W_EXEC_ADD   = 16'h010A; // a=1, add
    localparam logic [15:0] W_EXEC_SUB   = 16'h0102;
    localparam logic [15:0] W_EXEC_AND   = 16'h010E;
    localparam logic [15:0] W_ALUWB      = 16'h0A00; // regdst regwrite
    localparam logic [15:0] W_BR_TAKEN   = 16'h8112; // pcen a=1 pcsrc=01 sub
    localparam logic [15:0] W_BR_NOT     = 16'h0112;
    localparam logic [15:0] W_ADDIWB     = 16'h0200; // regwrite
    localparam logic [15:0] W_JUMP       = 16'h8020; // pcen pcsrc=10

    logic             clk;
    logic             reset;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0]       alusrcb, pcsrc;
    logic [2:0]       alucontrol;
    logic             illegal;
    logic [CNT_W-1:0] instret;
    logic [15:0]      ctrl;

    int checks = 0;
    int errors = 0;
    int exp_instret = 0;

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcen       (pcen),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .instret    (instret)
    );

    assign ctrl = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                   alusrcb, pcsrc, alucontrol, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the current cycle's control word (and that alucontrol is known),
    // then advance one clock.
    task automatic step(input string tag, input logic [15:0] exp);
        #1;
        check(tag, {16'h0, ctrl}, {16'h0, exp});
        check({tag, "_aluknown"}, {31'h0, $isunknown(alucontrol)}, 32'h0);
        tick();
    endtask

    task automatic check_instret(input string tag, input bit retired);
        if (retired) exp_instret = (exp_instret + 1) % (1 << CNT_W);
        check({tag, "_instret"}, {{(32-CNT_W){1'b0}}, instret}, exp_instret);
    endtask

    // Runs one instruction with mem_ready held high; n control words expected.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int n,
                             input logic [15:0] s0, input logic [15:0] s1,
                             input logic [15:0] s2, input logic [15:0] s3,
                             input bit retired);
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = 1'b1;
        step($sformatf("%s_c0", tag), s0);
        step($sformatf("%s_c1", tag), s1);
        step($sformatf("%s_c2", tag), s2);
        if (n > 3) step($sformatf("%s_c3", tag), s3);
        check_instret(tag, retired);
    endtask

    initial begin
        reset     = 1'b0;
        opcode    = 6'b000000;
        funct     = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Reset held with mem_ready high: FETCH outputs, no strobes.
        tick();
        tick();
        #1;
        check("rst_ctrl", {16'h0, ctrl}, {16'h0, W_FETCH_WAIT});
        check_instret("rst", 1'b0);
        reset = 1'b1;
        #1;

        // add: FETCH, DECODE, EXECUTE(add), ALUWB; instret 0 -> 1.
        run_instr("add", 6'b000000, 6'b100000, 1'b0, 4,
                  W_FETCH_RDY, W_DECODE, W_EXEC_ADD, W_ALUWB, 1'b1);

        // lw interrupted by reset in MEMREAD.
        opcode = 6'b100011;
        step("lwrst_fetch", W_FETCH_RDY);
        step("lwrst_decode", W_DECODE);
        step("lwrst_memadr", W_MEMADR);
        mem_ready = 1'b0;
        step("lwrst_memread", W_MEMREAD);
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("lwrst_in_reset", {16'h0, ctrl}, {16'h0, W_FETCH_WAIT});
        exp_instret = 0;
        check_instret("lwrst_in_reset", 1'b0);
        tick();
        #1;
        check("lwrst_hold", {16'h0, ctrl}, {16'h0, W_FETCH_WAIT});
        reset = 1'b1;
        #1;
        check_instret("lwrst_release", 1'b0);

        // beq taken and not taken; both retire.
        run_instr("beq_t", 6'b000100, 6'b000000, 1'b1, 3,
                  W_FETCH_RDY, W_DECODE, W_BR_TAKEN, 16'h0, 1'b1);
        run_instr("beq_n", 6'b000100, 6'b000000, 1'b0, 3,
                  W_FETCH_RDY, W_DECODE, W_BR_NOT, 16'h0, 1'b1);

        // lw with 2 FETCH waits and 3 MEMREAD waits: 10 cycles.
        opcode    = 6'b100011;
        mem_ready = 1'b0;
        step("lw_fw0", W_FETCH_WAIT);
        step("lw_fw1", W_FETCH_WAIT);
        mem_ready = 1'b1;
        step("lw_fetch", W_FETCH_RDY);
        step("lw_decode", W_DECODE);
        step("lw_memadr", W_MEMADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("lw_mrw%0d", i), W_MEMREAD);
        check_instret("lw_mid", 1'b0);
        mem_ready = 1'b1;
        step("lw_memread", W_MEMREAD);
        step("lw_memwb", W_MEMWB);
        check_instret("lw", 1'b1);

        // sw and addi.
        run_instr("sw", 6'b101011, 6'b000000, 1'b0, 4,
                  W_FETCH_RDY, W_DECODE, W_MEMADR, W_MEMWRITE, 1'b1);
        run_instr("addi", 6'b001000, 6'b000000, 1'b0, 4,
                  W_FETCH_RDY, W_DECODE, W_MEMADR, W_ADDIWB, 1'b1);

        // Other R-type ops.
        run_instr("sub", 6'b000000, 6'b100010, 1'b0, 4,
                  W_FETCH_RDY, W_DECODE, W_EXEC_SUB, W_ALUWB, 1'b1);
        run_instr("and", 6'b000000, 6'b100100, 1'b0, 4,
                  W_FETCH_RDY, W_DECODE, W_EXEC_AND, W_ALUWB, 1'b1);

        // Unknown opcode: back in FETCH with a one-cycle illegal pulse.
        opcode = 6'b111111;
        step("ilop_fetch", W_FETCH_RDY);
        step("ilop_decode", W_DECODE);
        mem_ready = 1'b0;
        step("ilop_pulse", W_FETCH_WAIT | 16'h0001);
        check_instret("ilop", 1'b0);
        step("ilop_cleared", W_FETCH_WAIT);

        // Unknown funct: add on the ALU, no writeback, illegal pulse.
        opcode    = 6'b000000;
        funct     = 6'b000111;
        mem_ready = 1'b1;
        step("ilfn_fetch", W_FETCH_RDY);
        step("ilfn_decode", W_DECODE);
        step("ilfn_exec", W_EXEC_ADD);
        mem_ready = 1'b0;
        step("ilfn_pulse", W_FETCH_WAIT | 16'h0001);
        check_instret("ilfn", 1'b0);
        step("ilfn_cleared", W_FETCH_WAIT);

        // 16 jumps walk the 4-bit counter through the 15 -> 0 wrap.
        for (int i = 0; i < 16; i++) begin
            run_instr($sformatf("j%0d", i), 6'b000010, 6'b000000, 1'b0, 3,
                      W_FETCH_RDY, W_DECODE, W_JUMP, 16'h0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so a stuck run still ends with a summary.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
